// File: rtl/note_player.sv
// Square-wave tone generator for the melody sequencer: plays the current note, inserts an
// articulation gap, then pulses note_adv so the note counter steps to the next index.
module note_player #(
  parameter int BEAT_DIV    = 12500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int PITCH_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] note_pitch,
  input  logic [1:0] note_len,
  input  logic       song_wrap,
  output logic       speaker,
  output logic       note_adv,
  output logic       busy,
  output logic [3:0] cur_pitch
);

  localparam int PW = $clog2(BEAT_DIV);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, TONE, GAP, ADV} state_t;

  state_t        state, state_next;
  logic [1:0]    len_q;
  logic [15:0]   tone_cnt;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   half_period;
  logic [15:0]   half_m1;
  logic          tone_done;
  logic          gap_done;
  logic          run_tone;
  logic          run_gap;

  // Half-period in clk cycles at 50 MHz (25e6 / f); code 0 is a rest.
  function automatic logic [15:0] half_base(input logic [3:0] p);
    case (p)
      4'd1:    half_base = 16'd50620;
      4'd2:    half_base = 16'd47778;
      4'd3:    half_base = 16'd45097;
      4'd4:    half_base = 16'd42566;
      4'd5:    half_base = 16'd40177;
      4'd6:    half_base = 16'd37922;
      4'd7:    half_base = 16'd35793;
      4'd8:    half_base = 16'd33784;
      4'd9:    half_base = 16'd31888;
      4'd10:   half_base = 16'd30098;
      4'd11:   half_base = 16'd28409;
      4'd12:   half_base = 16'd26815;
      4'd13:   half_base = 16'd25310;
      4'd14:   half_base = 16'd23889;
      4'd15:   half_base = 16'd15944;
      default: half_base = 16'd0;
    endcase
  endfunction

  assign half_period = half_base(cur_pitch) >> PITCH_SHIFT;
  assign half_m1     = half_period - 16'd1;
  assign tone_done   = (pre_cnt == PRE_LAST) && (beat_cnt == len_q);
  assign gap_done    = (gap_cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else if (song_wrap && state != IDLE) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    state_next = LOAD;
        LOAD:    state_next = TONE;
        TONE:    if (tone_done) state_next = (GAP_CYCLES == 0) ? ADV : GAP;
        GAP:     if (gap_done) state_next = ADV;
        ADV:     state_next = LOAD;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters only run while staying in the same state, so any exit (end of note, wrap,
  // enable drop) leaves them cleared and silences the speaker on the very next cycle.
  assign run_tone = (state == TONE) && (state_next == TONE);
  assign run_gap  = (state == GAP) && (state_next == GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pitch <= '0;
      len_q     <= '0;
      tone_cnt  <= '0;
      pre_cnt   <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      speaker   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (state == LOAD) begin
        cur_pitch <= note_pitch;
        len_q     <= note_len;
      end
      if (run_tone) begin
        if (pre_cnt == PRE_LAST) begin
          pre_cnt  <= '0;
          beat_cnt <= beat_cnt + 2'd1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
        if (cur_pitch == 4'd0) begin
          tone_cnt <= '0;
          speaker  <= 1'b0;
        end else if (tone_cnt == half_m1) begin
          tone_cnt <= '0;
          speaker  <= ~speaker;
        end else begin
          tone_cnt <= tone_cnt + 16'd1;
        end
      end else begin
        tone_cnt <= '0;
        pre_cnt  <= '0;
        beat_cnt <= '0;
        speaker  <= 1'b0;
      end
      gap_cnt <= run_gap ? gap_cnt + 1'b1 : '0;
    end
  end

  assign busy     = (state != IDLE);
  assign note_adv = (state == ADV);

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: two instances (with and without a gap) checked every cycle against
// a time-since-LOAD reference model, plus directed note, wrap, enable and reset scenarios.
module tb_note_player;

  localparam int BD_A = 1000, GAP_A = 50, SH_A = 8;
  localparam int BD_B = 20,   GAP_B = 0,  SH_B = 11;

  logic clk = 1'b0;
  logic rst, en, song_wrap;
  logic [3:0] pitch_a, pitch_b, cp_a, cp_b;
  logic [1:0] len_a, len_b;
  logic spk_a, adv_a, busy_a, spk_b, adv_b, busy_b;

  logic [3:0] rom_p_a [8];
  logic [1:0] rom_l_a [8];
  logic [3:0] rom_p_b [8];
  logic [1:0] rom_l_b [8];
  logic [2:0] idx_a = '0, idx_b = '0;

  assign pitch_a = rom_p_a[idx_a];
  assign len_a   = rom_l_a[idx_a];
  assign pitch_b = rom_p_b[idx_b];
  assign len_b   = rom_l_b[idx_b];

  note_player #(.BEAT_DIV(BD_A), .GAP_CYCLES(GAP_A), .PITCH_SHIFT(SH_A)) u_dut (
    .clk(clk), .rst(rst), .en(en), .note_pitch(pitch_a), .note_len(len_a),
    .song_wrap(song_wrap), .speaker(spk_a), .note_adv(adv_a), .busy(busy_a), .cur_pitch(cp_a)
  );

  note_player #(.BEAT_DIV(BD_B), .GAP_CYCLES(GAP_B), .PITCH_SHIFT(SH_B)) u_dut_nogap (
    .clk(clk), .rst(rst), .en(en), .note_pitch(pitch_b), .note_len(len_b),
    .song_wrap(song_wrap), .speaker(spk_b), .note_adv(adv_b), .busy(busy_b), .cur_pitch(cp_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Note counter feeding the song ROM lookup.
  always @(posedge clk) begin
    if (rst || song_wrap) begin
      idx_a <= '0;
      idx_b <= '0;
    end else begin
      if (adv_a) idx_a <= idx_a + 3'd1;
      if (adv_b) idx_b <= idx_b + 3'd1;
    end
  end

  // Reference model: whether a note is active, cycles since its LOAD, and latched note data.
  int         base_hp [16] = '{0, 50620, 47778, 45097, 42566, 40177, 37922, 35793,
                               33784, 31888, 30098, 28409, 26815, 25310, 23889, 15944};
  int         bd_t  [2] = '{BD_A, BD_B};
  int         gap_t [2] = '{GAP_A, GAP_B};
  int         sh_t  [2] = '{SH_A, SH_B};
  string      nm    [2] = '{"a", "b"};
  bit         m_act [2] = '{0, 0};
  int         m_t   [2] = '{0, 0};
  logic [3:0] m_cp  [2] = '{4'd0, 4'd0};
  logic [1:0] m_len [2] = '{2'd0, 2'd0};
  bit         chk_on = 0;
  int         cyc = 0;

  function automatic int tone_len(input int d);
    return (int'(m_len[d]) + 1) * bd_t[d];
  endfunction

  task automatic expect_out(input int d, output logic s, output logic a, output logic b);
    int t, h;
    s = 1'b0; a = 1'b0; b = 1'b0;
    if (m_act[d]) begin
      b = 1'b1;
      t = m_t[d];
      if (t >= 1 && t <= tone_len(d) && m_cp[d] != 4'd0) begin
        h = base_hp[m_cp[d]] >> sh_t[d];
        s = (((t - 1) / h) % 2) == 1;
      end
      a = (t == tone_len(d) + gap_t[d] + 1);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] pin;
    logic [1:0] lin;
    cyc++;
    chk_on = 1;
    for (int d = 0; d < 2; d++) begin
      pin = (d == 0) ? pitch_a : pitch_b;
      lin = (d == 0) ? len_a : len_b;
      if (rst) begin
        m_act[d] = 0; m_t[d] = 0; m_cp[d] = 4'd0; m_len[d] = 2'd0;
      end else begin
        if (m_act[d] && m_t[d] == 0) begin
          m_cp[d] = pin; m_len[d] = lin;
        end
        if (!en) m_act[d] = 0;
        else if (!m_act[d]) begin m_act[d] = 1; m_t[d] = 0; end
        else if (song_wrap) m_t[d] = 0;
        else begin
          m_t[d]++;
          if (m_t[d] == tone_len(d) + gap_t[d] + 2) m_t[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic es, ea, eb;
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        expect_out(d, es, ea, eb);
        check($sformatf("%s.speaker", nm[d]), (d == 0) ? spk_a : spk_b, es);
        check($sformatf("%s.note_adv", nm[d]), (d == 0) ? adv_a : adv_b, ea);
        check($sformatf("%s.busy", nm[d]), (d == 0) ? busy_a : busy_b, eb);
        check($sformatf("%s.cur_pitch", nm[d]), (d == 0) ? cp_a : cp_b, m_cp[d]);
      end
    end
  end

  // Event monitor for the directed scenarios.
  int load_at = 0, adv_at = 0, adv_cnt = 0, toggles = 0;
  int load0_at = 0, adv0_at = 0, adv0_cnt = 0;
  logic pbusy_a = 1'b0, pspk_a = 1'b0, pbusy_b = 1'b0;

  always @(negedge clk) begin
    if (busy_a && !pbusy_a) load_at = cyc;
    if (adv_a) begin adv_at = cyc; adv_cnt++; end
    if (spk_a !== pspk_a) toggles++;
    if (busy_b && !pbusy_b) load0_at = cyc;
    if (adv_b) begin adv0_at = cyc; adv0_cnt++; end
    pbusy_a = busy_a; pspk_a = spk_a; pbusy_b = busy_b;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_adv_a(input int limit);
    int prev;
    bit seen;
    prev = adv_cnt;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (adv_cnt != prev) begin seen = 1; break; end
    end
    check("adv_a_seen", seen, 1);
  endtask

  task automatic wait_adv_b(input int limit);
    int prev;
    bit seen;
    prev = adv0_cnt;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (adv0_cnt != prev) begin seen = 1; break; end
    end
    check("adv_b_seen", seen, 1);
  endtask

  initial begin
    int prev, hold_cnt, off_cnt;
    bit seen;
    int seq_exp [3] = '{2, 6, 9};
    rom_p_a = '{4'd11, 4'd0, 4'd2, 4'd6, 4'd9, 4'd15, 4'd7, 4'd1};
    rom_l_a = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
    rom_p_b = '{4'd5, 4'd0, 4'd13, 4'd3, 4'd15, 4'd8, 4'd1, 4'd12};
    rom_l_b = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0};
    rst = 1'b1; en = 1'b0; song_wrap = 1'b0;
    repeat (3) step();
    check("rst_speaker", spk_a, 0);
    check("rst_note_adv", adv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_cur_pitch", cp_a, 0);
    rst = 1'b0;
    step();

    // Basic note: pitch 11 (half period 28409>>8 = 110), two beats of 1000, gap 50.
    toggles = 0;
    en = 1'b1;
    wait_adv_a(5000);
    check("basic_toggles", toggles, 18);
    check("basic_adv_offset", adv_at - load_at, 1 + 2000 + 50);
    prev = adv_at;
    toggles = 0;

    // Rest note: one beat, speaker silent, note period 1 + 1000 + 50 + 1.
    wait_adv_a(3000);
    check("rest_period", adv_at - prev, 1052);
    check("rest_toggles", toggles, 0);
    check("rest_cur_pitch", cp_a, 0);
    prev = adv_at;

    for (int k = 0; k < 3; k++) begin
      wait_adv_a(3000);
      check("seq_period", adv_at - prev, 1052);
      check("seq_cur_pitch", cp_a, seq_exp[k]);
      prev = adv_at;
    end

    // Wrap in the middle of the 4-beat note at index 5.
    repeat (1500) step();
    check("wrap_pre_pitch", cp_a, 15);
    hold_cnt = adv_cnt;
    song_wrap = 1'b1;
    step();
    song_wrap = 1'b0;
    check("wrap_load_busy", busy_a, 1);
    check("wrap_load_speaker", spk_a, 0);
    check("wrap_no_adv", adv_cnt, hold_cnt);
    step();
    check("wrap_new_pitch", cp_a, 11);

    // Drop enable in the gap of that note (TONE covers cycles 1..2000 after LOAD).
    repeat (2009) step();
    en = 1'b0;
    step();
    check("drop_busy", busy_a, 0);
    check("drop_speaker", spk_a, 0);
    repeat (5) step();
    check("drop_no_adv", adv_cnt, hold_cnt);
    toggles = 0;
    en = 1'b1;
    wait_adv_a(5000);
    check("replay_adv_offset", adv_at - load_at, 2051);
    check("replay_toggles", toggles, 18);
    check("replay_cur_pitch", cp_a, 11);

    // Reset in the middle of a tone with the speaker high.
    wait_adv_a(3000);
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (spk_a) begin seen = 1; break; end
    end
    check("spk_rise_seen", seen, 1);
    rst = 1'b1;
    step();
    check("midrst_speaker", spk_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_cur_pitch", cp_a, 0);
    check("midrst_note_adv", adv_a, 0);
    rst = 1'b0;
    step();
    check("postrst_load", busy_a, 1);

    // No-gap instance: ADV directly follows TONE.
    wait_adv_b(400);
    check("nogap_adv_offset", adv0_at - load0_at, 1 + (int'(rom_l_b[0]) + 1) * BD_B);

    // Randomized phase over fresh song contents.
    for (int i = 0; i < 8; i++) begin
      rom_p_a[i] = 4'($urandom_range(0, 15));
      rom_l_a[i] = 2'($urandom_range(0, 3));
      rom_p_b[i] = 4'($urandom_range(0, 15));
      rom_l_b[i] = 2'($urandom_range(0, 3));
    end
    off_cnt = 0;
    for (int i = 0; i < 40000; i++) begin
      song_wrap = 1'b0;
      rst = 1'b0;
      if (off_cnt > 0) begin
        off_cnt--;
        if (off_cnt == 0) en = 1'b1;
      end else if ($urandom_range(0, 2999) == 0) begin
        en = 1'b0;
        off_cnt = $urandom_range(1, 40);
      end
      if ($urandom_range(0, 1999) == 0) song_wrap = 1'b1;
      if ($urandom_range(0, 14999) == 0) rst = 1'b1;
      step();
    end
    en = 1'b0;
    song_wrap = 1'b0;
    rst = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
